target_compact: RTL and testbench
=================================

TARGET_COMPACT -- requirements
Module: target_compact

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  input  1  request to encode; accepted only in IDLE.
REQ-004 SHALL have port target256  input  256  full target; sampled only on the accepting edge.
REQ-005 SHALL have port busy  output  1  high from the edge after acceptance until done is deasserted.
REQ-006 SHALL have port done  output  1  single-cycle pulse; target32 is valid while it is high.
REQ-007 SHALL have port target32  output  32  compact nBits result, {size[7:0], mantissa[23:0]}.

Function
REQ-008 SHALL implement FSM IDLE -> SCAN -> NORM -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-009 SHALL, in IDLE with start=1, capture target256 into an internal register, set byte index to 31, and enter SCAN.
REQ-010 SHALL, in SCAN, test one byte per cycle, from byte 31 (MSB) downward, and stop at the first nonzero byte or at byte 0.
REQ-011 SHALL set size = index+1 when the stopping byte is nonzero, and size = 0 when all bytes are zero.
REQ-012 SHALL, in NORM, form the mantissa:
- size<=3: low 24 bits shifted left by 8*(3-size).
- size>3: target shifted right by 8*(size-3), truncated to 24 bits.
REQ-013 SHALL, when mantissa bit 23 is set, shift the mantissa right by 8 and increment size; the result never has bit 23 set.
REQ-014 SHALL register target32 at the NORM->DONE edge, pulse done in DONE, and hold target32 until the next DONE.
REQ-015 SHALL give a start-to-done latency of L+3 rising edges, counted from the accepting edge, where L = leading zero bytes (min(L,31)).
REQ-016 SHALL ignore start while busy; a request is never queued.
REQ-017 SHALL encode an all-zero target as 0x00000000.
REQ-018 SHALL encode an all-ones target as 0x2100FFFF; the size field is 8 bits and never wraps.

Reset
REQ-019 SHALL, on rst, asynchronously force IDLE, busy=0, done=0 and target32=0x00000000.
REQ-020 SHALL, on rst mid-operation, abort the encode with no done pulse; the first start after rst release is accepted normally.

Configuration
REQ-021 SHALL honour macro TARGET_COMPACT_FAST_SCAN_EN.
- Defined: SCAN tests one 32-bit word per cycle (words 7..0) and priority-encodes the byte within the word in the same cycle; latency = floor(L/4)+3 edges.
- Undefined: byte-serial scan per REQ-010, latency per REQ-015.
REQ-022 SHALL produce target32 values identical in both configurations.

Structure
REQ-023 SHALL take the following from shared package target_pkg:
- FSM state enum;
- constants TARGET_W=256, COMPACT_W=32, MANT_W=24, MANT_SIGN_BIT=23, SIZE_BIAS=3.
REQ-024 SHALL use one sub-module, target_lead_byte (4-byte priority encoder giving the highest nonzero byte index and a nonzero flag), instantiated only when TARGET_COMPACT_FAST_SCAN_EN is defined.

Verification
REQ-025 Bench SHALL cover target 0xFFFF<<208 -> target32=0x1D00FFFF; done after 7 edges (4 edges when fast).
REQ-026 Bench SHALL cover target 0x12 -> 0x01120000, and target 0x80 -> 0x02008000 (sign normalisation).
REQ-027 Bench SHALL cover all-zero target -> 0x00000000, done after 34 edges (L capped at 31; 10 edges when fast); all-ones target -> 0x2100FFFF, done after 3 edges.
REQ-028 Bench SHALL cover start held high throughout an encode -> exactly one done per accepted request; the second request is accepted only in IDLE after DONE.
REQ-029 Bench SHALL cover rst asserted in SCAN -> busy=0 and target32=0 immediately, with no done pulse; a following start of 0x1D00FFFF's target encodes correctly.
REQ-030 Bench SHALL cover target256 changed during busy -> result reflects the value captured at acceptance.

Source files
------------

// File: rtl/target_pkg.sv
// -----------------------------------------------------------------------------
// target_pkg
// Shared types and constants for the 256-bit target -> 32-bit compact (nBits)
// encoder. Holds the FSM state enum and the field widths that the encoder and
// its helper sub-module use.
// No ports (package).
// -----------------------------------------------------------------------------
package target_pkg;

    localparam int TARGET_W      = 256;  // full target width
    localparam int COMPACT_W     = 32;   // {size[7:0], mantissa[23:0]}
    localparam int MANT_W        = 24;   // mantissa field width
    localparam int MANT_SIGN_BIT = 23;   // must never be set in a result
    localparam int SIZE_BIAS     = 3;    // mantissa holds three bytes

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/target_lead_byte.sv
// -----------------------------------------------------------------------------
// target_lead_byte
// Four-byte priority encoder: reports the index of the most significant
// nonzero byte in a 32-bit word, plus a flag telling whether any byte is
// nonzero. Purely combinational.
// Ports:
//   word     in  32  word under test
//   idx      out 2   index (3 = bits 31:24) of highest nonzero byte
//   nonzero  out 1   high when any bit of word is set
// -----------------------------------------------------------------------------
module target_lead_byte (
    input  logic [31:0] word,
    output logic [1:0]  idx,
    output logic        nonzero
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        idx     = 2'd0;
        nonzero = |word;
        if (word[31:24] != 8'h00)
            idx = 2'd3;
        else if (word[23:16] != 8'h00)
            idx = 2'd2;
        else if (word[15:8] != 8'h00)
            idx = 2'd1;
    end

endmodule

// File: rtl/target_compact.sv
// -----------------------------------------------------------------------------
// target_compact
// Encodes a 256-bit target into the 32-bit compact "nBits" form
// {size[7:0], mantissa[23:0]}. An IDLE -> SCAN -> NORM -> DONE sequencer
// finds the most significant nonzero byte, then forms and sign-normalises the
// mantissa in a single cycle.
//
// Build option: TARGET_COMPACT_FAST_SCAN_EN
//   defined   - SCAN walks 32-bit words 7..0 and priority-encodes the byte
//               inside the word (target_lead_byte) in the same cycle.
//   undefined - SCAN walks bytes 31..0, one per cycle.
//   Both builds produce identical target32 values.
//
// Ports:
//   clk        in  1    clock, rising edge
//   rst        in  1    asynchronous, active-high reset
//   start      in  1    encode request, accepted only in IDLE
//   target256  in  256  target, captured on the accepting edge
//   busy       out 1    high from acceptance until done drops
//   done       out 1    one-cycle pulse, target32 valid while high
//   target32   out 32   compact result, held until the next done
// -----------------------------------------------------------------------------
module target_compact
    import target_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TARGET_W-1:0]  target256,
    output logic                 busy,
    output logic                 done,
    output logic [COMPACT_W-1:0] target32
);

    state_t                state;
    logic [TARGET_W-1:0]   tgt_q;
    logic [7:0]            size_q;

`ifdef TARGET_COMPACT_FAST_SCAN_EN
    // Word index 7..0; word k covers bits 32k+31 .. 32k.
    logic [2:0]  idx_q;
    logic [31:0] scan_word;
    logic [1:0]  lead_idx;
    logic        lead_nz;

    assign scan_word = tgt_q[{idx_q, 5'b00000} +: 32];

    target_lead_byte u_lead_byte (
        .word    (scan_word),
        .idx     (lead_idx),
        .nonzero (lead_nz)
    );
`else
    // Byte index 31..0; byte k covers bits 8k+7 .. 8k.
    logic [4:0] idx_q;
    logic [7:0] scan_byte;

    assign scan_byte = tgt_q[{idx_q, 3'b000} +: 8];
`endif

    // Mantissa extraction and sign normalisation, evaluated while in NORM.
    logic [MANT_W-1:0]    mant_raw;
    logic [COMPACT_W-1:0] compact;

    always_comb begin
        mant_raw = '0;
        compact  = '0;
        if (size_q <= 8'(SIZE_BIAS))
            // size is 0..3 here, so the two low bits give 3-size directly.
            mant_raw = tgt_q[MANT_W-1:0] << {2'(SIZE_BIAS) - size_q[1:0], 3'b000};
        else
            mant_raw = MANT_W'(tgt_q >> {size_q - 8'(SIZE_BIAS), 3'b000});

        // A set top bit would read as a negative mantissa: move it one byte
        // down and grow the exponent instead. size tops out at 33, no wrap.
        if (mant_raw[MANT_SIGN_BIT])
            compact = {size_q + 8'd1, 8'h00, mant_raw[MANT_W-1:8]};
        else
            compact = {size_q, mant_raw};
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tgt_q    <= '0;
            idx_q    <= '0;
            size_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            target32 <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tgt_q <= target256;
                        idx_q <= '1;        // top byte / top word
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
`ifdef TARGET_COMPACT_FAST_SCAN_EN
                    if (lead_nz) begin
                        size_q <= {3'b000, idx_q, lead_idx} + 8'd1;
                        state  <= ST_NORM;
                    end else if (idx_q == 3'd0) begin
                        size_q <= 8'd0;
                        state  <= ST_NORM;
                    end else begin
                        idx_q <= idx_q - 3'd1;
                    end
`else
                    if (scan_byte != 8'h00) begin
                        size_q <= {3'b000, idx_q} + 8'd1;
                        state  <= ST_NORM;
                    end else if (idx_q == 5'd0) begin
                        size_q <= 8'd0;
                        state  <= ST_NORM;
                    end else begin
                        idx_q <= idx_q - 5'd1;
                    end
`endif
                end

                ST_NORM: begin
                    target32 <= compact;
                    done     <= 1'b1;
                    state    <= ST_DONE;
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_target_compact.sv
// -----------------------------------------------------------------------------
// tb_target_compact
// Self-checking bench for target_compact: directed corner targets, held-start,
// mid-scan reset, and randomized targets scored against a behavioural model.
// -----------------------------------------------------------------------------
module tb_target_compact;

`ifdef TARGET_COMPACT_FAST_SCAN_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [255:0] target256 = '0;
    logic         busy;
    logic         done;
    logic [31:0]  target32;

    int checks   = 0;
    int failures = 0;

    target_compact dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .target256 (target256),
        .busy      (busy),
        .done      (done),
        .target32  (target32)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: size = byte length of the value, mantissa = its top three
    // bytes (zero padded on the right), then fix a set sign bit.
    function automatic logic [31:0] model_encode(input logic [255:0] t);
        int           nbits = 0;
        int           nbytes;
        int           sz;
        logic [255:0] sh;
        logic [23:0]  m;
        for (int b = 0; b < 256; b++)
            if (t[b]) nbits = b + 1;
        nbytes = (nbits + 7) / 8;
        if (nbytes <= 3) sh = t << (8 * (3 - nbytes));
        else             sh = t >> (8 * (nbytes - 3));
        m  = sh[23:0];
        sz = nbytes;
        if (m[23]) begin
            m  = m >> 8;
            sz = sz + 1;
        end
        return {sz[7:0], m};
    endfunction

    function automatic int model_latency(input logic [255:0] t);
        int nbits = 0;
        int nbytes;
        int lz;
        for (int b = 0; b < 256; b++)
            if (t[b]) nbits = b + 1;
        nbytes = (nbits + 7) / 8;
        lz = (nbytes == 0) ? 31 : 32 - nbytes;
        return FAST ? (lz / 4 + 3) : (lz + 3);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One request: start for a single edge, scramble target256 while busy,
    // then count edges (accepting edge = 1) until done.
    task automatic run_encode(input logic [255:0] t, input logic [31:0] exp_v,
                              input int exp_lat, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        start     = 1'b1;
        target256 = t;
        @(posedge clk);
        #1;
        start     = 1'b0;
        target256 = rand256();
        n         = 1;
        check({tag, "_busy"}, busy, 1);
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_target32"}, target32, exp_v);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_clear"}, busy, 0);
        check({tag, "_hold"}, target32, exp_v);
    endtask

    initial begin
        logic [255:0] t;
        logic [255:0] t_a;
        logic [255:0] t_b;
        int           done_cnt;
        int           e1;
        int           e2;
        logic [31:0]  v1;
        logic [31:0]  v2;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_target32", target32, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed corner targets
        t = 256'hFFFF << 208;
        run_encode(t, 32'h1D00FFFF, FAST ? 4 : 7, "t_ffff208");
        t = 256'h12;
        run_encode(t, 32'h01120000, FAST ? 10 : 34, "t_12");
        t = 256'h80;
        run_encode(t, 32'h02008000, FAST ? 10 : 34, "t_80");
        t = '0;
        run_encode(t, 32'h00000000, FAST ? 10 : 34, "t_zero");
        t = '1;
        run_encode(t, 32'h2100FFFF, 3, "t_ones");

        // start held high across two encodes; target changes after acceptance
        t_a = '1;
        t_b = 256'h80 << 248;
        done_cnt = 0; e1 = -1; e2 = -1; v1 = '0; v2 = '0;
        @(negedge clk);
        start     = 1'b1;
        target256 = t_a;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) target256 = t_b;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin e1 = e; v1 = target32; end
                else if (done_cnt == 2) begin e2 = e; v2 = target32; end
            end
        end
        start = 1'b0;
        check("hold_done_count", done_cnt, 2);
        check("hold_first_edge", e1, 3);
        check("hold_second_edge", e2, 7);
        check("hold_first_val", v1, 32'h2100FFFF);
        check("hold_second_val", v2, 32'h21008000);
        @(posedge clk);
        #1;
        check("hold_idle", busy, 0);

        // Reset during SCAN aborts with no done pulse
        t = 256'hFFFF << 208;
        @(negedge clk);
        start     = 1'b1;
        target256 = t;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_target32", target32, 0);
        @(negedge clk) rst = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        run_encode(t, 32'h1D00FFFF, FAST ? 4 : 7, "after_rst");

        // Randomized targets with random leading-zero depth
        for (int i = 0; i < 40; i++) begin
            t = rand256() >> (8 * $urandom_range(0, 32));
            if ($urandom_range(0, 3) == 0)
                t = t & ~(256'h7F << (8 * $urandom_range(0, 31)));
            run_encode(t, model_encode(t), model_latency(t), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
